network_if_rx_fifo: RTL and testbench

Receiving-end elastic buffer for `network_if`. It terminates a `network_if` link whose ready path may be registered upstream, and absorbs up to `SLACK` beats that are still in flight after it deasserts ready. Beats are stored in a circular FIFO and replayed on a `network_if` master port with standard valid/ready flow control. It sits at the consumer side of any `network_if` hop that contains register stages.

---
 rtl/network_pkg.sv | 14 +
 rtl/network_if.sv | 17 +
 rtl/network_rx_fifo_mem.sv | 26 ++
 rtl/network_if_rx_fifo.sv | 117 +++++++++++
 tb/tb_network_if_rx_fifo.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/network_pkg.sv
// Shared definitions for network_if links: beat layout and drop counter width.
package network_pkg;

  localparam int unsigned NET_VAL_W  = 32;
  localparam int unsigned NET_ID_W   = 8;
  localparam int unsigned DROP_CNT_W = 16;

  // One stored beat: routing id above payload value.
  typedef struct packed {
    logic [NET_ID_W-1:0]  id;
    logic [NET_VAL_W-1:0] val;
  } net_beat_t;

endpackage

// File: rtl/network_if.sv
// Valid/ready beat link carrying a payload value and an id.
interface network_if
  import network_pkg::*;
#(
  parameter int unsigned VAL_W = NET_VAL_W,
  parameter int unsigned ID_W  = NET_ID_W
) ();

  logic [VAL_W-1:0] val;
  logic [ID_W-1:0]  id;
  logic             valid;
  logic             ready;

  modport master (output val, output id, output valid, input ready);
  modport slave  (input val, input id, input valid, output ready);

endinterface

// File: rtl/network_rx_fifo_mem.sv
// Storage array for the rx FIFO: synchronous write, asynchronous read, no reset.
module network_rx_fifo_mem
  import network_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  net_beat_t                wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output net_beat_t                rdata_o
);

  net_beat_t mem_q [DEPTH];

  // Write the incoming beat into the addressed slot.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/network_if_rx_fifo.sv
// Receiving-end elastic buffer: keeps beats that arrive after ready falls
// (up to SLACK of them) and replays them first-word-fall-through downstream.
module network_if_rx_fifo
  import network_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SLACK = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  network_if.slave                     in,
  network_if.master                    out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [DROP_CNT_W-1:0]        drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] SLACK_CNT = CW'(SLACK);

  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic      push, pop, drop;
  net_beat_t wr_beat;
  net_beat_t head_beat;

  // Flow-control decisions; accept ignores in.ready so slack beats are kept.
  always_comb begin
    pop  = (count_q != '0) && out.ready;
    push = in.valid && ((count_q != FULL_CNT) || pop);
    drop = in.valid && !push;
  end

  // Next-state for pointers, occupancy, ready and drop bookkeeping.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end
    ready_d = (FULL_CNT - count_d) > SLACK_CNT;
  end

  // State registers; reset empties the buffer and clears the flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Pack the incoming beat for storage.
  always_comb begin
    wr_beat     = '0;
    wr_beat.id  = in.id;
    wr_beat.val = in.val;
  end

  network_rx_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (wr_beat),
    .raddr_i (rptr_q),
    .rdata_o (head_beat)
  );

  // The array has no reset, so the head is masked to zero while empty.
  always_comb begin
    out.valid = (count_q != '0);
    out.val   = out.valid ? head_beat.val : '0;
    out.id    = out.valid ? head_beat.id  : '0;
  end

  assign in.ready   = ready_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_network_if_rx_fifo.sv
// Self-checking bench for network_if_rx_fifo against a queue-based model.
module tb_network_if_rx_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned SLACK = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] drop_count;

  network_if in_if ();
  network_if out_if ();

  network_if_rx_fifo #(
    .DEPTH (DEPTH),
    .SLACK (SLACK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in_if),
    .out        (out_if),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO contents as a queue of {id, val}.
  logic [39:0] q[$];
  int          drops   = 0;
  logic        rdy_exp = 1'b0;
  int          n_chk   = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [39:0] head;
    head = (q.size() != 0) ? q[0] : 40'd0;
    chk("count",     64'(count),         64'(q.size()));
    chk("out_valid", 64'(out_if.valid),  64'(q.size() != 0));
    chk("out_val",   64'(out_if.val),    64'(head[31:0]));
    chk("out_id",    64'(out_if.id),     64'(head[39:32]));
    chk("in_ready",  64'(in_if.ready),   64'(rdy_exp));
    chk("overflow",  64'(overflow),      64'(drops > 0));
    chk("drop_cnt",  64'(drop_count),    (drops > 65535) ? 64'hFFFF : 64'(drops));
  endtask

  task automatic step(input logic v, input logic [7:0] id, input logic [31:0] val,
                      input logic r, input bit do_chk);
    bit pop, push;
    @(negedge clk);
    in_if.valid  = v;
    in_if.id     = id;
    in_if.val    = val;
    out_if.ready = r;
    @(posedge clk);
    pop  = (q.size() != 0) && r;
    push = v && ((q.size() < DEPTH) || pop);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back({id, val});
    if (v && !push) drops++;
    rdy_exp = (int'(DEPTH) - q.size()) > int'(SLACK);
    #1;
    if (do_chk) check_all();
  endtask

  task automatic step_rand(input logic v, input logic r, input bit do_chk);
    step(v, 8'($urandom), $urandom, r, do_chk);
  endtask

  task automatic drain();
    for (int i = 0; i < int'(DEPTH) + 2 && q.size() != 0; i++) step_rand(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    in_if.valid  = 1'b0;
    in_if.id     = '0;
    in_if.val    = '0;
    out_if.ready = 1'b0;

    // Reset release with idle input.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();
    step_rand(1'b0, 1'b0, 1'b1);

    // Streaming with out.ready high: each beat appears one cycle after push.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(i), 32'(i * 3), 1'b1, 1'b1);
      chk("stream_val", 64'(out_if.val), 64'(i * 3));
      chk("cnt_le1", 64'(count <= 4'd1), 64'd1);
    end
    step_rand(1'b0, 1'b1, 1'b1);

    // Fill with stalled output: ready drops at count 6, beats 7..8 kept, 9 dropped.
    for (int i = 1; i <= 9; i++) begin
      step_rand(1'b1, 1'b0, 1'b1);
      if (i == 5) chk("ready_at5", 64'(in_if.ready), 64'd1);
      if (i == 6) chk("ready_at6", 64'(in_if.ready), 64'd0);
    end
    chk("full_cnt", 64'(count), 64'd8);
    chk("ovf_first", 64'(overflow), 64'd1);
    chk("drop_first", 64'(drop_count), 64'd1);
    drain();

    // Full with simultaneous push and pop: no drop, pointers wrap.
    for (int i = 0; i < 8; i++) step_rand(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step_rand(1'b1, 1'b1, 1'b1);
      chk("full_pp_cnt", 64'(count), 64'd8);
    end
    chk("full_pp_drops", 64'(drop_count), 64'd1);
    drain();

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step_rand(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b1);
    drain();

    // Asynchronous reset mid-burst at count 5.
    for (int i = 0; i < 5; i++) step_rand(1'b1, 1'b0, 1'b1);
    chk("pre_rst_cnt", 64'(count), 64'd5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    drops   = 0;
    rdy_exp = 1'b0;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    in_if.valid = 1'b0;
    #1;
    check_all();
    step(1'b1, 8'hA5, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("post_rst_val", 64'(out_if.val), 64'hDEADBEEF);
    chk("post_rst_id",  64'(out_if.id),  64'hA5);
    for (int i = 0; i < 200; i++)
      step_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 1'b1);

    // Saturate the drop counter.
    for (int i = 0; i < 70000; i++) step_rand(1'b1, 1'b0, 1'b0);
    check_all();
    chk("drop_sat", 64'(drop_count), 64'hFFFF);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    step_rand(1'b1, 1'b0, 1'b1);
    chk("drop_sat_hold", 64'(drop_count), 64'hFFFF);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
